// File: rtl/fir_sum_tree_log_pkg.sv
// Shared helpers for the adaptive-filter datapath (sum tree, error and update stages).
//   clog2      : ceiling log2, 0 for n <= 1; sets the number of adder-tree levels
//   tree_nodes : operand count left after k pairwise levels starting from ord leaves
//   sat_hit    : true when s does not fit in a w-bit two's-complement word
//   sat_clip   : s clamped to the w-bit two's-complement range
package fir_sum_tree_log_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Repeated ceil-halving collapses to a single ceil division by 2^k.
  function automatic int tree_nodes(input int ord, input int k);
    return (ord + (1 << k) - 1) >> k;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] s, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] s, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/DelayNUnit.sv
// N-deep registered delay line of W-bit words with synchronous active-high reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every stage
//   d_i   : word entering the line
//   q_o   : d_i delayed by N clock edges
module DelayNUnit #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[N-1];

endmodule

// File: rtl/fir_sum_tree_stage.sv
// One registered level of the adder tree: adds operand pairs (2j, 2j+1) into
// IN_W+1-bit results. An odd last operand is sign-extended and registered alone.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears all result registers
//   din_i  : N_IN signed operands, operand j at [IN_W*j +: IN_W]
//   dout_o : N_OUT signed results, result j at [OUT_W*j +: OUT_W]
module fir_sum_tree_stage #(
  parameter  int IN_W  = 16,
  parameter  int N_IN  = 2,
  localparam int OUT_W = IN_W + 1,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN*IN_W-1:0]   din_i,
  output logic [N_OUT*OUT_W-1:0] dout_o
);

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic signed [IN_W-1:0]  a;
    logic signed [OUT_W-1:0] sum_d;
    logic signed [OUT_W-1:0] sum_q;

    assign a = din_i[2*j*IN_W +: IN_W];

    if (2*j + 1 < N_IN) begin : g_add
      logic signed [IN_W-1:0] b;
      assign b     = din_i[(2*j+1)*IN_W +: IN_W];
      assign sum_d = OUT_W'(a) + OUT_W'(b);
    end else begin : g_pass
      assign sum_d = OUT_W'(a);
    end

    always_ff @(posedge clk) begin
      if (reset) sum_q <= '0;
      else       sum_q <= sum_d;
    end

    assign dout_o[j*OUT_W +: OUT_W] = sum_q;
  end

endmodule

// File: rtl/fir_sum_tree_log.sv
// Pipelined adder tree behind the log-domain tap multiplier bank. Sums ORD signed
// tap products (Q.QP) into y[n], saturates to WIDTH bits and flags clipping.
// One sample per clock, latency STAGES+1 edges, no stall.
//   clk           : rising-edge clock
//   reset         : synchronous, active-high; clears data and valid pipelines
//   tap_in_packed : ORD signed taps, tap j at [WIDTH*j +: WIDTH]
//   tap_valid     : qualifies the taps presented this cycle
//   filter_out    : saturated sum, signed, same Q format as the taps
//   out_valid     : one-cycle qualifier per sample
//   sat_out       : sum was clipped (only meaningful with out_valid)
module fir_sum_tree_log
  import fir_sum_tree_log_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int ORD   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ORD*WIDTH-1:0]   tap_in_packed,
  input  logic                   tap_valid,
  output logic [WIDTH-1:0]       filter_out,
  output logic                   out_valid,
  output logic                   sat_out
);

  localparam int STAGES = clog2(ORD);
  localparam int LAT    = STAGES + 1;
  localparam int SW     = WIDTH + STAGES;

  // The binary point is untouched by summation; only its legality is checked.
  if (QP < 0 || QP >= WIDTH) begin : g_bad_qp
    $error("QP must lie in [0, WIDTH)");
  end

  function automatic logic [WIDTH-1:0] sat_word(input logic signed [SW-1:0] s);
    logic signed [63:0] c;
    c = sat_clip(64'(s), WIDTH);
    return c[WIDTH-1:0];
  endfunction

  function automatic logic sat_flag(input logic signed [SW-1:0] s);
    return sat_hit(64'(s), WIDTH);
  endfunction

  logic signed [SW-1:0] sum_s;

  // Stages 1..STAGES: each level halves the operand count and grows one bit,
  // so the full sum always fits and nothing can overflow before saturation.
  for (genvar k = 1; k <= STAGES; k++) begin : g_st
    localparam int IW = WIDTH + k - 1;
    localparam int NI = tree_nodes(ORD, k - 1);
    localparam int NO = tree_nodes(ORD, k);
    logic [NI*IW-1:0]     din;
    logic [NO*(IW+1)-1:0] dout;

    if (k == 1) begin : g_first
      assign din = tap_in_packed;
    end else begin : g_next
      assign din = g_st[k-1].dout;
    end

    fir_sum_tree_stage #(.IN_W(IW), .N_IN(NI)) u_stage (
      .clk   (clk),
      .reset (reset),
      .din_i (din),
      .dout_o(dout)
    );
  end

  if (STAGES == 0) begin : g_single
    assign sum_s = tap_in_packed;
  end else begin : g_tree
    assign sum_s = g_st[STAGES].dout;
  end

  // Final stage: saturating output register.
  logic [WIDTH-1:0] filt_q;
  logic             sat_q;
  logic             vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      filt_q <= sat_word(sum_s);
      sat_q  <= sat_flag(sum_s);
    end
  end

  DelayNUnit #(.W(1), .N(LAT)) u_vld_dly (
    .clk  (clk),
    .reset(reset),
    .d_i  (tap_valid),
    .q_o  (vld_q)
  );

  assign filter_out = filt_q;
  assign out_valid  = vld_q;
  assign sat_out    = sat_q & vld_q;

endmodule

// File: tb/tb_fir_sum_tree_log.sv
module tb_fir_sum_tree_log;

  localparam int LAT64 = 7;
  localparam int HMAX  = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic [1023:0] tap_bus;
  logic          tap_valid;
  logic [15:0]   filter_out;
  logic          out_valid;
  logic          sat_out;

  logic [79:0]   bus5;
  logic          vld5;
  logic [15:0]   fo5;
  logic          ov5;
  logic          so5;

  logic [15:0]   bus1;
  logic          vld1;
  logic [15:0]   fo1;
  logic          ov1;
  logic          so1;

  logic [15:0]   taps [64];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int vcount = 0;

  int hist_sum [HMAX];
  bit hist_vld [HMAX];
  bit hist_rst [HMAX];

  always #5 clk = ~clk;

  always_comb begin
    tap_bus = '0;
    for (int j = 0; j < 64; j++) tap_bus[j*16 +: 16] = taps[j];
  end

  fir_sum_tree_log #(.WIDTH(16), .QP(12), .ORD(64)) dut (
    .clk(clk), .reset(reset), .tap_in_packed(tap_bus), .tap_valid(tap_valid),
    .filter_out(filter_out), .out_valid(out_valid), .sat_out(sat_out)
  );

  fir_sum_tree_log #(.WIDTH(16), .QP(12), .ORD(5)) dut5 (
    .clk(clk), .reset(reset), .tap_in_packed(bus5), .tap_valid(vld5),
    .filter_out(fo5), .out_valid(ov5), .sat_out(so5)
  );

  fir_sum_tree_log #(.WIDTH(16), .QP(12), .ORD(1)) dut1 (
    .clk(clk), .reset(reset), .tap_in_packed(bus1), .tap_valid(vld1),
    .filter_out(fo1), .out_valid(ov1), .sat_out(so1)
  );

  // Reference arithmetic: clamp an exact integer sum to 16-bit signed.
  function automatic int satv(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic bit satf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural history: what the 64-tap DUT saw at every rising edge.
  always @(posedge clk) begin
    int s;
    s = 0;
    for (int j = 0; j < 64; j++) s += int'($signed(taps[j]));
    if (ecnt < HMAX) begin
      hist_sum[ecnt] = s;
      hist_vld[ecnt] = tap_valid;
      hist_rst[ecnt] = reset;
    end
    ecnt++;
  end

  // Output after edge e reflects the sample taken at edge e-L+1, unless a reset
  // was sampled at any edge in between, in which case everything reads zero.
  always @(negedge clk) begin
    int e;
    int m;
    int ev;
    bit rr;
    bit evl;
    bit es;
    if (ecnt >= LAT64 && ecnt <= HMAX) begin
      e  = ecnt - 1;
      m  = e - LAT64 + 1;
      rr = 1'b0;
      for (int i = m; i <= e; i++) rr |= hist_rst[i];
      if (rr) begin
        ev = 0; evl = 1'b0; es = 1'b0;
      end else begin
        ev  = satv(hist_sum[m]);
        evl = hist_vld[m];
        es  = satf(hist_sum[m]) & evl;
      end
      chk("model_out_valid", 32'(out_valid), 32'(evl));
      chk("model_filter_out", 32'(filter_out), 32'(ev[15:0]));
      chk("model_sat_out", 32'(sat_out), 32'(es));
    end
  end

  always @(negedge clk) if (out_valid) vcount++;

  task automatic step(input bit v, input bit r);
    tap_valid = v;
    reset     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse64(input string nm, input logic [15:0] ev, input bit es);
    tap_valid = 1'b1;
    @(posedge clk);
    #1;
    tap_valid = 1'b0;
    repeat (LAT64 - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, "_value"}, 32'(filter_out), 32'(ev));
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_sat"}, 32'(sat_out), 32'(es));
    @(negedge clk);
    chk({nm, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int j = 0; j < 64; j++) taps[j] = v;
  endtask

  task automatic rand_taps(input bit wide);
    for (int j = 0; j < 64; j++)
      taps[j] = wide ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
  endtask

  initial begin
    bit pat [7];
    bit got [7];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; tap_valid = 1'b0; fill(16'h0000);
    bus5 = '0; vld5 = 1'b0; bus1 = '0; vld1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_filter_out", 32'(filter_out), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sat_out", 32'(sat_out), 32'd0);
    chk("reset_ord5_valid", 32'(ov5), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) step(1'b0, 1'b0);

    // All ones -> 64 in LSBs
    fill(16'h0001);
    pulse64("all_ones", 16'h0040, 1'b0);

    fill(16'h7FFF);
    pulse64("all_max", 16'h7FFF, 1'b1);
    fill(16'h8000);
    pulse64("all_min", 16'h8000, 1'b1);

    for (int j = 0; j < 64; j++) taps[j] = j[0] ? 16'hFF9C : 16'h0064;
    pulse64("alternating", 16'h0000, 1'b0);

    fill(16'h0000); taps[0] = 16'h1000;
    pulse64("unity_tap0", 16'h1000, 1'b0);

    // Exact range limits must not be flagged; one LSB past must be.
    fill(16'h0000); taps[0] = 16'h7FFF;
    pulse64("exact_max", 16'h7FFF, 1'b0);
    taps[5] = 16'h0001;
    pulse64("max_plus_one", 16'h7FFF, 1'b1);
    fill(16'h0000); taps[0] = 16'h8000;
    pulse64("exact_min", 16'h8000, 1'b0);
    taps[9] = 16'hFFFF;
    pulse64("min_minus_one", 16'h8000, 1'b1);

    // Valid pattern with random taps, data checked by the model.
    for (int i = 0; i < 7; i++) begin
      rand_taps(i[0]);
      step(pat[i], 1'b0);
    end
    tap_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got[i] = out_valid;
    end
    for (int i = 0; i < 7; i++) chk($sformatf("valid_pattern_%0d", i), 32'(got[i]), 32'(pat[i]));
    @(posedge clk);
    #1;
    repeat (4) step(1'b0, 1'b0);

    // Mid-stream reset: in-flight samples must vanish.
    for (int i = 0; i < 3; i++) begin
      rand_taps(1'b0);
      step(1'b1, 1'b0);
    end
    rand_taps(1'b0);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("midreset_filter_out", 32'(filter_out), 32'd0);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_sat_out", 32'(sat_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vcount = 0;
    step(1'b0, 1'b0);
    rand_taps(1'b0);
    step(1'b1, 1'b0);
    rand_taps(1'b1);
    repeat (12) step(1'b0, 1'b0);
    chk("post_reset_valid_count", 32'(vcount), 32'd1);

    // Small builds: ORD=5 (L=4) and ORD=1 (L=1).
    for (int j = 0; j < 5; j++) bus5[j*16 +: 16] = 16'(j + 1);
    vld5 = 1'b1;
    @(posedge clk);
    #1;
    vld5 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ord5_value", 32'(fo5), 32'h000F);
    chk("ord5_valid", 32'(ov5), 32'd1);
    chk("ord5_sat", 32'(so5), 32'd0);
    @(negedge clk);
    chk("ord5_valid_one_cycle", 32'(ov5), 32'd0);

    @(posedge clk);
    #1;
    bus1 = 16'h1234;
    vld1 = 1'b1;
    @(posedge clk);
    #1;
    vld1 = 1'b0;
    @(negedge clk);
    chk("ord1_value", 32'(fo1), 32'h1234);
    chk("ord1_valid", 32'(ov1), 32'd1);
    chk("ord1_sat", 32'(so1), 32'd0);
    @(negedge clk);
    chk("ord1_valid_one_cycle", 32'(ov1), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
